// File: rtl/fp_pkg.sv
// Shared widths, constants and stage payloads for the pipelined single-precision subtractor.
package fp_pkg;

    localparam int EXP_W   = 8;
    localparam int MANT_W  = 23;
    localparam int GUARD_W = 2;
    localparam int SIG_W   = MANT_W + 1;        // mantissa with hidden bit
    localparam int ALN_W   = SIG_W + GUARD_W;   // aligned mantissa width
    localparam int LZC_W   = 5;

    localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;
    localparam logic [31:0]      QNAN    = 32'h7FC00000;

    // Unpacked operands after the magnitude swap
    typedef struct packed {
        logic               sign;
        logic [EXP_W-1:0]   exp;
        logic [EXP_W-1:0]   diff;
        logic [SIG_W-1:0]   mant_big;
        logic [SIG_W-1:0]   mant_lit;
        logic               eff_sub;
        logic               special;
        logic [31:0]        spec_val;
        logic               spec_ovf;
    } s1_t;

    // Raw sum / difference awaiting normalization
    typedef struct packed {
        logic               sign;
        logic [EXP_W-1:0]   exp;
        logic [ALN_W:0]     sum;
        logic               special;
        logic [31:0]        spec_val;
        logic               spec_ovf;
    } s2_t;

    // Denormals flush to a zero significand; normals get the hidden bit back.
    function automatic logic [SIG_W-1:0] f_sig(input logic [30:0] x);
        return (x[30:23] == '0) ? '0 : {1'b1, x[22:0]};
    endfunction

endpackage

// File: rtl/fp_lzc26.sv
// Leading-zero counter for the 26-bit aligned mantissa; all-zero input yields 26.
module fp_lzc26 (
    input  logic [25:0] i_val,
    output logic [4:0]  o_cnt
);

    always_comb begin
        o_cnt = 5'd26;
        // Ascending scan so the highest set bit has the final say
        for (int i = 0; i < 26; i++) begin
            if (i_val[i]) o_cnt = 5'(25 - i);
        end
    end

endmodule

// File: rtl/fp_subtractor.sv
// Three-stage valid/ready IEEE-754 single subtractor (out = a - b), truncating, denormals flushed.
module fp_subtractor
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out,
    output logic        overflow
);

    logic [3:1]  r_vld_pipe;
    s1_t         r_s1;
    s2_t         r_s2;
    logic [31:0] r_out;
    logic        r_ovf;

    logic w_adv1, w_adv2, w_adv3;

    // ---------------- S1: unpack, swap, specials ----------------
    logic [31:0] w_b_neg, w_big, w_lit;
    logic        w_a_inf, w_b_inf, w_swap;
    s1_t         w_s1;

    assign w_b_neg = {~b[31], b[30:0]};
    assign w_a_inf = (a[30:23] == EXP_INF);
    assign w_b_inf = (b[30:23] == EXP_INF);
    assign w_swap  = (b[30:0] > a[30:0]);
    assign w_big   = w_swap ? w_b_neg : a;
    assign w_lit   = w_swap ? a : w_b_neg;

    always_comb begin
        w_s1          = '0;
        w_s1.sign     = w_big[31];
        w_s1.exp      = w_big[30:23];
        w_s1.diff     = w_big[30:23] - w_lit[30:23];
        w_s1.mant_big = f_sig(w_big[30:0]);
        w_s1.mant_lit = f_sig(w_lit[30:0]);
        w_s1.eff_sub  = w_big[31] ^ w_lit[31];
        // Infinity handling outranks bitwise equality so inf - inf still yields NaN
        if (w_a_inf && w_b_inf) begin
            w_s1.special  = 1'b1;
            w_s1.spec_val = (a[31] == b[31]) ? QNAN : a;
            w_s1.spec_ovf = 1'b1;
        end else if (w_a_inf) begin
            w_s1.special  = 1'b1;
            w_s1.spec_val = a;
            w_s1.spec_ovf = 1'b1;
        end else if (w_b_inf) begin
            w_s1.special  = 1'b1;
            w_s1.spec_val = {~b[31], EXP_INF, {MANT_W{1'b0}}};
            w_s1.spec_ovf = 1'b1;
        end else if (a == b) begin
            w_s1.special  = 1'b1;
            w_s1.spec_val = '0;
            w_s1.spec_ovf = 1'b0;
        end
    end

    // ---------------- S2: align and add/subtract ----------------
    logic [ALN_W-1:0] w_big_al, w_lit_al;
    s2_t              w_s2;

    assign w_big_al = {r_s1.mant_big, {GUARD_W{1'b0}}};
    assign w_lit_al = (r_s1.diff >= 8'd26) ? '0 : ({r_s1.mant_lit, {GUARD_W{1'b0}}} >> r_s1.diff);

    always_comb begin
        w_s2          = '0;
        w_s2.sign     = r_s1.sign;
        w_s2.exp      = r_s1.exp;
        w_s2.special  = r_s1.special;
        w_s2.spec_val = r_s1.spec_val;
        w_s2.spec_ovf = r_s1.spec_ovf;
        // big >= little by construction, so the difference never goes negative
        if (r_s1.eff_sub) w_s2.sum = {1'b0, w_big_al} - {1'b0, w_lit_al};
        else              w_s2.sum = {1'b0, w_big_al} + {1'b0, w_lit_al};
    end

    // ---------------- S3: normalize, truncate, range check ----------------
    logic [LZC_W-1:0]  w_lzc;
    logic [ALN_W-1:0]  w_norm;
    logic signed [9:0] w_exp_n;
    logic [31:0]       w_res;
    logic              w_res_ovf;
    logic              w_unused_bits;

    fp_lzc26 u_lzc (
        .i_val (r_s2.sum[ALN_W-1:0]),
        .o_cnt (w_lzc)
    );

    assign w_norm  = r_s2.sum[ALN_W] ? r_s2.sum[ALN_W:1] : (r_s2.sum[ALN_W-1:0] << w_lzc);
    assign w_exp_n = r_s2.sum[ALN_W] ? $signed({2'b00, r_s2.exp}) + 10'sd1
                                     : $signed({2'b00, r_s2.exp}) - $signed({5'b00000, w_lzc});
    assign w_unused_bits = ^{w_norm[ALN_W-1], w_norm[GUARD_W-1:0]};

    always_comb begin
        w_res     = {r_s2.sign, w_exp_n[7:0], w_norm[ALN_W-2:GUARD_W]};
        w_res_ovf = 1'b0;
        if (r_s2.special) begin
            w_res     = r_s2.spec_val;
            w_res_ovf = r_s2.spec_ovf;
        end else if (r_s2.sum == '0 || w_exp_n <= 10'sd0) begin
            w_res     = '0;
        end else if (w_exp_n >= 10'sd255) begin
            w_res     = {r_s2.sign, EXP_INF, {MANT_W{1'b0}}};
            w_res_ovf = 1'b1;
        end
    end

    // ---------------- handshake and stage registers ----------------
    assign w_adv3   = !r_vld_pipe[3] | out_ready;
    assign w_adv2   = !r_vld_pipe[2] | w_adv3;
    assign w_adv1   = !r_vld_pipe[1] | w_adv2;
    assign in_ready = w_adv1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            r_s1       <= '0;
            r_s2       <= '0;
            r_out      <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_adv1) begin
                r_vld_pipe[1] <= in_valid;
                if (in_valid) r_s1 <= w_s1;
            end
            if (w_adv2) begin
                r_vld_pipe[2] <= r_vld_pipe[1];
                if (r_vld_pipe[1]) r_s2 <= w_s2;
            end
            if (w_adv3) begin
                r_vld_pipe[3] <= r_vld_pipe[2];
                if (r_vld_pipe[2]) begin
                    r_out <= w_res;
                    r_ovf <= w_res_ovf;
                end
            end
        end
    end

    assign out_valid = r_vld_pipe[3];
    assign out       = r_out;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_fp_subtractor.sv
// Directed-vector bench for fp_subtractor: arithmetic, specials, backpressure and mid-flight reset.
module tb_fp_subtractor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_ready, out_valid, overflow;
    logic [31:0] out;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] bp_a [5];
    logic [31:0] bp_b [5];
    logic [31:0] bp_e [5];

    always #5 clk = ~clk;

    fp_subtractor dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .overflow  (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    // One isolated pair with out_ready high; checks latency and the result
    task automatic run_one(input string tag, input logic [31:0] va, input logic [31:0] vb,
                           input logic [31:0] eo, input logic eovf);
        @(negedge clk);
        a = va; b = vb; in_valid = 1'b1; out_ready = 1'b1;
        #1 chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk({tag, ".lat0"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        #1 chk({tag, ".lat1"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        chk({tag, ".vld"}, 32'(out_valid), 32'd1);
        chk({tag, ".out"}, out, eo);
        chk({tag, ".ovf"}, 32'(overflow), 32'(eovf));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nxt, got;
        bp_a[0] = 32'h40400000; bp_b[0] = 32'h3F800000; bp_e[0] = 32'h40000000; // 3-1
        bp_a[1] = 32'h40800000; bp_b[1] = 32'h3F800000; bp_e[1] = 32'h40400000; // 4-1
        bp_a[2] = 32'h40000000; bp_b[2] = 32'h40400000; bp_e[2] = 32'hBF800000; // 2-3
        bp_a[3] = 32'h3F800000; bp_b[3] = 32'h3F800000; bp_e[3] = 32'h00000000; // 1-1
        bp_a[4] = 32'h41200000; bp_b[4] = 32'h40A00000; bp_e[4] = 32'h40A00000; // 10-5

        #12;
        chk("rst.vld", 32'(out_valid), 32'd0);
        chk("rst.out", out, 32'h0);
        chk("rst.ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst.rdy", 32'(in_ready), 32'd1);

        run_one("sub3m1",   32'h40400000, 32'h3F800000, 32'h40000000, 1'b0);
        run_one("carry",    32'h3F800000, 32'hBF800000, 32'h40000000, 1'b0);
        run_one("equal",    32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0);
        run_one("cancel",   32'h3F800000, 32'h3F7FFFFF, 32'h33800000, 1'b0);
        run_one("negres",   32'h40000000, 32'h40400000, 32'hBF800000, 1'b0);
        run_one("infinf",   32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b1);
        run_one("ovfl",     32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 1'b1);
        run_one("binf",     32'h3F800000, 32'hFF800000, 32'h7F800000, 1'b1);
        run_one("ainf",     32'hFF800000, 32'h3F800000, 32'hFF800000, 1'b1);
        run_one("infopp",   32'h7F800000, 32'hFF800000, 32'h7F800000, 1'b1);
        run_one("denorm",   32'h00000001, 32'h00000002, 32'h00000000, 1'b0);
        run_one("bigdiff",  32'h3F800000, 32'h00400000, 32'h3F800000, 1'b0);
        run_one("underflw", 32'h00800000, 32'h00C00000, 32'h00000000, 1'b0);

        // Backpressure: out_ready low for the first 6 cycles, 5 back-to-back pairs
        nxt = 0;
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 6);
            if (nxt < 5) begin
                in_valid = 1'b1; a = bp_a[nxt]; b = bp_b[nxt];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc < 6) chk($sformatf("bp.rdy%0d", cyc), 32'(in_ready), (cyc < 3) ? 32'd1 : 32'd0);
            if (cyc >= 3 && cyc < 6) begin
                chk($sformatf("bp.stall_vld%0d", cyc), 32'(out_valid), 32'd1);
                chk($sformatf("bp.stall_out%0d", cyc), out, bp_e[0]);
            end
            if (out_valid && out_ready) begin
                chk($sformatf("bp.res%0d", got), out, bp_e[got]);
                got++;
            end
            if (in_valid && in_ready) nxt++;
        end
        chk("bp.count", 32'(got), 32'd5);
        @(negedge clk);
        in_valid = 1'b0;

        // Reset with three results in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = bp_a[i]; b = bp_b[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("mid.vld_before", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1 chk("mid.vld_async", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1 chk("mid.rdy", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1 chk($sformatf("mid.stale%0d", i), 32'(out_valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_subtractor.md
# fp_subtractor

Pipelined IEEE-754 single-precision subtractor computing out = a − b for the Maxnet inhibition update (x_i − ε·Σx_j). It is the counterpart of the combinational floating-point adder: same number format, same infinity and overflow conventions. It is wrapped in a 3-stage valid/ready pipeline so it can sit between the multiplier and the neuron register file at one result per cycle.

## Interface
- No parameters. Widths are fixed at 32-bit float.
- clk    in   1   rising-edge clock
- rst_n  in   1   asynchronous active-low reset
- in_valid  in  1   operand pair valid
- in_ready  out 1   block can accept the pair this cycle
- a  in  32  minuend (sign[31], exp[30:23], mant[22:0])
- b  in  32  subtrahend
- out_valid  out 1   result valid
- out_ready  in  1   consumer accepts the result
- out  out 32  result a − b
- overflow  out 1   result or an input is infinity or NaN; qualified by out_valid

## Operation
- Effective operation is a + (−b): flip b[31], then follow add/subtract logic.
- Input exp 0 is treated as zero, so denormals are flushed. Input exp 255 is treated as infinity regardless of mantissa.
- S1 (unpack):
  - Restore the hidden bit to form 24-bit mantissas.
  - Swap operands so |big| ≥ |little|, comparing {exp, mant}.
  - diff = exp_big − exp_little.
  - Detect special cases.
  - Result sign = sign_big.
- S2 (align/add):
  - Extend each mantissa with 2 guard bits to 26 bits.
  - Shift little right by diff. If diff ≥ 26, little becomes 0. No sticky bit.
  - Equal effective signs: 27-bit sum. Otherwise: big − little, which is never negative.
- S3 (normalize):
  - If sum[26] is set, shift right 1 and add 1 to the exponent.
  - Otherwise left-shift by leading-zero count (lzc) and subtract lzc from the exponent.
  - Truncate the guard bits (round toward zero).
  - Zero mantissa → +0 (0x00000000).
  - Exponent ≤ 0 after normalize → +0.
  - Exponent ≥ 255 → {sign, 0xFF, 0}, overflow = 1.
- Special cases, bypassing the S2/S3 arithmetic but travelling the pipeline with the same latency:
  - a inf, b finite → a, overflow = 1.
  - b inf, a finite → {~b[31], 0xFF, 0}, overflow = 1.
  - Both inf with equal sign → 0x7FC00000, overflow = 1.
  - Both inf with opposite sign → a, overflow = 1.
  - a == b bitwise → 0x00000000, overflow = 0.

## Timing
- Reset values: out_valid = 0, out = 0, overflow = 0, all stage valid flags = 0. in_ready = 1 from the first cycle after reset release.
- Latency: a pair accepted on edge k (in_valid & in_ready) appears with out_valid = 1 after edge k+2.
- Throughput: 1 result per cycle while out_ready = 1.
- Handshake:
  - A stage advances when it is empty or the stage after it advances.
  - The output stage holds out, overflow and out_valid stable while out_valid & !out_ready.
  - in_ready = !s1_valid | s1_advance (combinational from out_ready). No bubbles under continuous flow.
- Ordering: results leave in acceptance order. Nothing is dropped or duplicated under any out_ready pattern.
- Full pipeline: with out_ready low, at most 3 pairs are held and in_ready drops on the cycle after the 3rd acceptance.
- Simultaneous accept and emit while full is allowed; the pipeline shifts in the same cycle.
- Reset mid-operation: all in-flight results are discarded immediately, asynchronously. No output is produced for them.
- out and overflow are don't-care while out_valid = 0, but must be registered (no combinational path from a/b).

## Structure
- Package fp_pkg:
  - EXP_W = 8, MANT_W = 23, GUARD_W = 2
  - EXP_INF = 8'hFF
  - QNAN = 32'h7FC00000
  - Stage payload structs s1_t and s2_t.
- Sub-module fp_lzc26: combinational leading-zero counter, 26-bit input, 5-bit count, used in S3.
- Top module holds the three stage registers and the handshake logic.

## Test plan
- 0x40400000 (3.0) − 0x3F800000 (1.0), out_ready = 1 → out = 0x40000000, overflow = 0, out_valid after edge k+2.
- 0x3F800000 − 0xBF800000 (1 − (−1)) → 0x40000000 via the carry path. 0x3F800000 − 0x3F800000 → 0x00000000.
- Massive cancellation: 0x3F800000 − 0x3F7FFFFF → 0x33800000 (2^-24; exercises the guard bits and lzc = 24).
- Specials:
  - 0x7F800000 − 0x7F800000 → 0x7FC00000, overflow = 1.
  - 0x7F7FFFFF − 0xFF7FFFFF → 0x7F800000, overflow = 1.
  - 0x3F800000 − 0xFF800000 → 0x7F800000, overflow = 1.
- Backpressure: issue 5 back-to-back pairs with out_ready = 0 for 6 cycles, then 1 → in_ready drops after 3 accepts, all 5 results arrive in order, out stable while stalled.
- Assert rst_n low with 3 results in flight → out_valid = 0 immediately. After release, in_ready = 1 and no stale result appears.
